// File: rtl/debug_monitor_access_if.sv
// Avalon-MM master bus used by the debug monitor to reach the debug memory.
// The master modport is the monitor side; the slave modport is the memory side.
interface debug_monitor_access_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/debug_monitor_access.sv
// Debug monitor memory access engine: turns JTAG take-strobes into single-word
// Avalon-MM reads/writes with auto-incrementing address and a waitrequest timeout.
module debug_monitor_access #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  debug_monitor_access_if.master avm
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  // The abort fires on the edge that completes the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [ADDR_W:0] WaitLimit = (ADDR_W + 1)'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] mon_areg_q;
  logic [31:0]       mon_dreg_q;
  logic              ready_q;
  logic              error_q;
  logic [ADDR_W:0]   wait_cnt_q;

  logic any_strobe;
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mon_areg_q <= '0;
      mon_dreg_q <= 32'h0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (take_action_ocimem_a) begin
            mon_areg_q <= jdo[25+ADDR_W:26];
            // A dropped lower-priority strobe outranks the error-clear request.
            if (take_action_ocimem_b || take_no_action_ocimem_a) begin
              error_q <= 1'b1;
            end else if (jdo[24]) begin
              error_q <= 1'b0;
            end
            if (jdo[25]) begin
              state_q    <= StRead;
              ready_q    <= 1'b0;
              wait_cnt_q <= '0;
            end
          end else if (take_action_ocimem_b) begin
            mon_dreg_q <= jdo[34:3];
            state_q    <= StWrite;
            ready_q    <= 1'b0;
            wait_cnt_q <= '0;
            if (take_no_action_ocimem_a) begin
              error_q <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            state_q    <= StRead;
            ready_q    <= 1'b0;
            wait_cnt_q <= '0;
          end
        end

        StRead, StWrite: begin
          if (any_strobe) begin
            error_q <= 1'b1;
          end
          if (!avm.avm_waitrequest) begin
            if (state_q == StRead) begin
              mon_dreg_q <= avm.avm_readdata;
            end
            mon_areg_q <= mon_areg_q + ADDR_W'(1);
            ready_q    <= 1'b1;
            state_q    <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + (ADDR_W + 1)'(1);
            if (wait_cnt_q == WaitLimit) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              error_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Bus strobes decode straight from the state register so they hold through stalls.
  assign avm.avm_read       = (state_q == StRead);
  assign avm.avm_write      = (state_q == StWrite);
  assign avm.avm_address    = {mon_areg_q, 2'b00};
  assign avm.avm_writedata  = mon_dreg_q;
  assign avm.avm_byteenable = 4'hF;

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

endmodule
